prog_load_ctrl: RTL and testbench
=================================

PROG_LOAD_CTRL -- requirements
Module: prog_load_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, meaning the instruction word width.
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, meaning the instruction memory word-address width (DEPTH = 2^ADDR_WIDTH).
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset, as these ports:
- clk  input  1  clock, all state on rising edge.
- arst_n  input  1  asynchronous active-low reset.
- start  input  1  begin (re)load of program image.
- abort  input  1  cancel load in progress.
- prog_len  input  ADDR_WIDTH+1  number of words to load, sampled on accepted start.
- s_valid  input  1  stream word valid.
- s_data  input  DATA_WIDTH  stream word.
- s_ready  output  1  stream word accepted when s_valid and s_ready are both high.
- mem_w_en  output  1  instruction memory write enable.
- mem_addr  output  ADDR_WIDTH  instruction memory word address.
- mem_wdata  output  DATA_WIDTH  instruction memory write data.
- prog_ready  output  1  core released to execute (drives the core's prog_ready).
- busy  output  1  load in progress.
- done  output  1  one-cycle pulse when load completes successfully.
- error  output  1  checksum failure, sticky until next start (checksum builds only).

Function
REQ-004 The FSM SHALL have states IDLE, LOAD, CHECK (checksum builds only), RUN and ERROR; state is registered.
REQ-005 In IDLE, a start with prog_len != 0 SHALL go to LOAD next cycle, latch len = min(prog_len, DEPTH) and clear the word counter to 0.
REQ-006 In IDLE, a start with prog_len == 0 SHALL be ignored; the FSM stays in IDLE.
REQ-007 In LOAD, s_ready SHALL be 1 and busy SHALL be 1; in every other state s_ready SHALL be 0.
REQ-008 Memory writes SHALL be combinational from the stream: mem_w_en = s_valid & s_ready & (state==LOAD), mem_addr = counter, mem_wdata = s_data.
REQ-009 The word counter SHALL increment by 1 per accepted beat in LOAD and never wrap; the beat with counter == len-1 is the last.
REQ-010 After the last beat, the FSM SHALL go to RUN next cycle (CHECK if PROG_LOAD_CHECKSUM_EN); idle cycles with s_valid=0 SHALL not advance the counter.
REQ-011 prog_ready SHALL be 1 exactly while in RUN; done SHALL pulse for one cycle on the first RUN cycle.
REQ-012 start in RUN or ERROR SHALL behave as REQ-005/006 from IDLE; prog_ready SHALL drop on the first LOAD cycle.
REQ-013 abort in LOAD or CHECK SHALL go to IDLE next cycle with no write in the abort cycle; abort in other states SHALL be ignored.
REQ-014 start and abort asserted together SHALL resolve abort-first; start is ignored that cycle.
REQ-015 start while in LOAD SHALL be ignored.

Reset
REQ-016 While arst_n = 0, the FSM SHALL be IDLE, the counter, len and checksum SHALL be 0, and s_ready, mem_w_en, prog_ready, busy, done and error SHALL be 0, asynchronously.
REQ-017 Reset asserted mid-load SHALL discard the load; no write SHALL occur after reset assertion.

Configuration
REQ-018 Macro PROG_LOAD_CHECKSUM_EN defined: the block SHALL keep a running DATA_WIDTH-bit sum (mod 2^DATA_WIDTH) of loaded words and include state CHECK.
- In CHECK, s_ready = 1 and one extra beat is accepted but not written (mem_w_en = 0).
- Beat equal to the sum: go to RUN.
- Otherwise: go to ERROR, error = 1, prog_ready = 0.
REQ-019 Macro PROG_LOAD_CHECKSUM_EN undefined: there SHALL be no CHECK or ERROR state and no sum register, and error SHALL be tied 0.

Verification
REQ-020 Reset, then start with prog_len=3 and beats 0x00000013, 0x00100093, 0x001080B3 back-to-back -> writes at addr 0,1,2; prog_ready=1 and done pulse on the cycle after the 3rd beat.
REQ-021 prog_len=4 with s_valid gaps of 2 cycles between beats -> exactly 4 writes at addr 0..3, no write during gaps, busy=1 throughout.
REQ-022 prog_len=300 with ADDR_WIDTH=8 -> exactly 256 writes, addr 0..255, then RUN.
REQ-023 abort and start together after the 2nd of 5 beats -> IDLE next cycle, no further writes, prog_ready=0.
REQ-024 Checksum build with words 1,2,3 then check word 6 -> RUN. Same words then check word 7 -> ERROR, error=1; a later start clears error.
REQ-025 arst_n pulsed low after the 1st beat -> all outputs 0 immediately, IDLE, no writes until a new start.

Source files
------------

// File: rtl/prog_load_ctrl.sv
// Program loader: streams an instruction image into instruction memory, then releases the core.
// Optional build macro PROG_LOAD_CHECKSUM_EN adds a trailing checksum beat with CHECK/ERROR states.
module prog_load_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  arst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH:0]   prog_len,
    input  logic                  s_valid,
    input  logic [DATA_WIDTH-1:0] s_data,
    output logic                  s_ready,
    output logic                  mem_w_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  prog_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [LW-1:0] DEPTH_L = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [LW-1:0] ONE_L   = {{ADDR_WIDTH{1'b0}}, 1'b1};

`ifdef PROG_LOAD_CHECKSUM_EN
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_CHECK = 3'd3,
        S_ERROR = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;
`endif

    state_t          r_state;
    state_t          w_next;
    logic [LW-1:0]   r_cnt;
    logic [LW-1:0]   r_len;
    logic            r_done;
    logic [LW-1:0]   w_len_clip;
    logic            w_start_ok;
    logic            w_load_beat;
    logic            w_last;
    logic            w_enter_load;
    logic            w_enter_run;
`ifdef PROG_LOAD_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] r_sum;
`endif

    // Abort wins over start in the same cycle, and a zero-length image is never started.
    assign w_start_ok   = start & ~abort & (prog_len != '0);
    assign w_len_clip   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
    assign w_load_beat  = s_valid & (r_state == S_LOAD) & ~abort;
    assign w_last       = (r_cnt == (r_len - ONE_L));
    assign w_enter_load = (r_state != S_LOAD) && (w_next == S_LOAD);
    assign w_enter_run  = (r_state != S_RUN) && (w_next == S_RUN);

    // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (w_start_ok) w_next = S_LOAD;
            end
            S_LOAD: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (w_load_beat && w_last) begin
`ifdef PROG_LOAD_CHECKSUM_EN
                    w_next = S_CHECK;
`else
                    w_next = S_RUN;
`endif
                end
            end
`ifdef PROG_LOAD_CHECKSUM_EN
            S_CHECK: begin
                if (abort) begin
                    w_next = S_IDLE;
                end else if (s_valid) begin
                    w_next = (s_data == r_sum) ? S_RUN : S_ERROR;
                end
            end
            S_ERROR: begin
                if (w_start_ok) w_next = S_LOAD;
            end
`endif
            S_RUN: begin
                if (w_start_ok) w_next = S_LOAD;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_len   <= '0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= w_enter_run;
            if (w_enter_load) begin
                r_len <= w_len_clip;
                r_cnt <= '0;
            end else if (w_load_beat) begin
                r_cnt <= r_cnt + ONE_L;
            end
        end
    end

`ifdef PROG_LOAD_CHECKSUM_EN
    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_sum <= '0;
        end else if (w_enter_load) begin
            r_sum <= '0;
        end else if (w_load_beat) begin
            r_sum <= r_sum + s_data;
        end
    end

    assign s_ready = (r_state == S_LOAD) || (r_state == S_CHECK);
    assign busy    = (r_state == S_LOAD) || (r_state == S_CHECK);
    assign error   = (r_state == S_ERROR);
`else
    assign s_ready = (r_state == S_LOAD);
    assign busy    = (r_state == S_LOAD);
    assign error   = 1'b0;
`endif

    // The write path is purely combinational, so reset removes mem_w_en the instant the state clears.
    assign mem_w_en   = w_load_beat;
    assign mem_addr   = r_cnt[ADDR_WIDTH-1:0];
    assign mem_wdata  = s_data;
    assign prog_ready = (r_state == S_RUN);
    assign done       = r_done;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Directed self-checking bench for prog_load_ctrl; writes are logged by a negedge monitor.
// The checksum scenario is compiled only when PROG_LOAD_CHECKSUM_EN is defined.
module tb_prog_load_ctrl;

    localparam int DW = 32;
    localparam int AW = 8;

    logic          clk;
    logic          arst_n;
    logic          start;
    logic          abort;
    logic [AW:0]   prog_len;
    logic          s_valid;
    logic [DW-1:0] s_data;
    logic          s_ready;
    logic          mem_w_en;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          prog_ready;
    logic          busy;
    logic          done;
    logic          error;

    int n_checks = 0;
    int n_pass   = 0;
    int wr_total = 0;
    logic [AW-1:0] log_addr [0:1023];
    logic [DW-1:0] log_data [0:1023];

    prog_load_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .start      (start),
        .abort      (abort),
        .prog_len   (prog_len),
        .s_valid    (s_valid),
        .s_data     (s_data),
        .s_ready    (s_ready),
        .mem_w_en   (mem_w_en),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .prog_ready (prog_ready),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required finish before 200000ns");
        $fatal(1, "watchdog expired");
    end

    always @(negedge clk) begin
        if (mem_w_en) begin
            if (wr_total < 1024) begin
                log_addr[wr_total] <= mem_addr;
                log_data[wr_total] <= mem_wdata;
            end
            wr_total <= wr_total + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h required 0x%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    function automatic logic [31:0] outs();
        return 32'({s_ready, mem_w_en, prog_ready, busy, done, error});
    endfunction

    logic [DW-1:0] prog3 [3];
    int base;

    initial begin
        prog3 = '{32'h0000_0013, 32'h0010_0093, 32'h0010_80B3};
        arst_n = 1'b0; start = 1'b0; abort = 1'b0; prog_len = '0;
        s_valid = 1'b0; s_data = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", outs(), 32'd0);
        arst_n = 1'b1;

        // Three back-to-back beats
        tick(); start = 1'b1; prog_len = 9'd3;
        mid(); check("idle_busy", 32'(busy), 32'd0);
        tick(); start = 1'b0; base = wr_total;
        mid(); check("load_busy", 32'(busy), 32'd1);
        check("load_s_ready", 32'(s_ready), 32'd1);
        check("load_prog_ready", 32'(prog_ready), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick(); s_valid = 1'b1; s_data = prog3[i];
            mid();
            check($sformatf("b2b_we%0d", i), 32'(mem_w_en), 32'd1);
            check($sformatf("b2b_addr%0d", i), 32'(mem_addr), 32'(i));
            check($sformatf("b2b_data%0d", i), mem_wdata, prog3[i]);
        end
        tick(); s_valid = 1'b0;
        mid();
        check("b2b_prog_ready", 32'(prog_ready), 32'd1);
        check("b2b_done", 32'(done), 32'd1);
        check("b2b_busy", 32'(busy), 32'd0);
        check("b2b_s_ready", 32'(s_ready), 32'd0);
        tick(); mid();
        check("b2b_done_pulse", 32'(done), 32'd0);
        check("b2b_run_hold", 32'(prog_ready), 32'd1);
        check("b2b_wr_cnt", 32'(wr_total - base), 32'd3);

        // Reload from RUN with two-cycle gaps between beats
        tick(); start = 1'b1; prog_len = 9'd4;
        mid(); check("reload_still_run", 32'(prog_ready), 32'd1);
        tick(); start = 1'b0; base = wr_total;
        mid();
        check("reload_prog_ready_drop", 32'(prog_ready), 32'd0);
        check("reload_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(); s_valid = 1'b1; s_data = 32'hA0 + 32'(i);
            mid();
            check($sformatf("gap_we%0d", i), 32'(mem_w_en), 32'd1);
            check($sformatf("gap_addr%0d", i), 32'(mem_addr), 32'(i));
            if (i < 3) begin
                for (int g = 0; g < 2; g++) begin
                    tick(); s_valid = 1'b0;
                    mid();
                    check($sformatf("gap_idle_we%0d_%0d", i, g), 32'(mem_w_en), 32'd0);
                    check($sformatf("gap_idle_busy%0d_%0d", i, g), 32'(busy), 32'd1);
                end
            end
        end
        tick(); s_valid = 1'b0;
        mid();
        check("gap_prog_ready", 32'(prog_ready), 32'd1);
        check("gap_wr_cnt", 32'(wr_total - base), 32'd4);
        for (int j = 0; j < 4; j++)
            check($sformatf("gap_log_addr%0d", j), 32'(log_addr[base + j]), 32'(j));

        // Oversized image clipped to the memory depth; a start mid-load is ignored
        tick(); start = 1'b1; prog_len = 9'd300;
        tick(); start = 1'b0; base = wr_total;
        for (int i = 0; i < 256; i++) begin
            tick(); s_valid = 1'b1; s_data = 32'(i) * 32'd3 + 32'd7;
            if (i == 100) begin
                start = 1'b1; prog_len = 9'd2;
            end else begin
                start = 1'b0;
            end
        end
        tick(); s_valid = 1'b0; start = 1'b0;
        mid();
        check("clip_prog_ready", 32'(prog_ready), 32'd1);
        check("clip_done", 32'(done), 32'd1);
        check("clip_wr_cnt", 32'(wr_total - base), 32'd256);
        for (int j = 0; j < 256; j++) begin
            check($sformatf("clip_addr%0d", j), 32'(log_addr[base + j]), 32'(j));
            check($sformatf("clip_data%0d", j), log_data[base + j], 32'(j) * 32'd3 + 32'd7);
        end

        // Abort together with start after the 2nd of 5 beats
        tick(); start = 1'b1; prog_len = 9'd5;
        tick(); start = 1'b0; base = wr_total;
        for (int i = 0; i < 2; i++) begin
            tick(); s_valid = 1'b1; s_data = 32'h50 + 32'(i);
        end
        tick(); abort = 1'b1; start = 1'b1; s_valid = 1'b1; s_data = 32'h52;
        mid(); check("abort_no_write", 32'(mem_w_en), 32'd0);
        tick(); abort = 1'b0; start = 1'b0;
        mid();
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_prog_ready", 32'(prog_ready), 32'd0);
        check("abort_s_ready", 32'(s_ready), 32'd0);
        repeat (3) tick();
        s_valid = 1'b0;
        tick();
        check("abort_wr_cnt", 32'(wr_total - base), 32'd2);

        // Zero-length start ignored in IDLE and RUN; abort ignored in RUN
        start = 1'b1; prog_len = 9'd0;
        tick(); start = 1'b0;
        mid(); check("zero_len_idle", 32'(busy), 32'd0);
        tick(); start = 1'b1; prog_len = 9'd1;
        tick(); start = 1'b0;
        tick(); s_valid = 1'b1; s_data = 32'h77;
        tick(); s_valid = 1'b0;
        mid(); check("len1_run", 32'(prog_ready), 32'd1);
        tick(); abort = 1'b1;
        tick(); abort = 1'b0;
        mid(); check("abort_in_run", 32'(prog_ready), 32'd1);
        tick(); start = 1'b1; prog_len = 9'd0;
        tick(); start = 1'b0;
        mid();
        check("zero_len_run_ready", 32'(prog_ready), 32'd1);
        check("zero_len_run_busy", 32'(busy), 32'd0);

        // Asynchronous reset after the 1st beat
        tick(); start = 1'b1; prog_len = 9'd3;
        tick(); start = 1'b0; base = wr_total;
        tick(); s_valid = 1'b1; s_data = 32'hC0;
        tick(); s_data = 32'hC1;
        #2 arst_n = 1'b0;
        #1 check("rst_mid_outs", outs(), 32'd0);
        tick(); tick();
        arst_n = 1'b1;
        repeat (3) tick();
        mid();
        check("rst_after_outs", outs(), 32'd0);
        check("rst_wr_cnt", 32'(wr_total - base), 32'd1);
        tick(); s_valid = 1'b0; start = 1'b1; prog_len = 9'd1;
        tick(); start = 1'b0;
        mid(); check("rst_restart_busy", 32'(busy), 32'd1);
        tick(); s_valid = 1'b1; s_data = 32'hD0;
        mid();
        check("rst_restart_we", 32'(mem_w_en), 32'd1);
        check("rst_restart_addr", 32'(mem_addr), 32'd0);
        tick(); s_valid = 1'b0;
        mid(); check("rst_restart_run", 32'(prog_ready), 32'd1);

`ifdef PROG_LOAD_CHECKSUM_EN
        // Checksum: sum(1,2,3)=6 passes, 7 fails and is cleared by the next start
        for (int pass = 0; pass < 2; pass++) begin
            tick(); start = 1'b1; prog_len = 9'd3;
            tick(); start = 1'b0;
            for (int i = 0; i < 3; i++) begin
                tick(); s_valid = 1'b1; s_data = 32'(i + 1);
            end
            tick(); s_data = (pass == 0) ? 32'd6 : 32'd7;
            mid();
            check($sformatf("cks_no_write%0d", pass), 32'(mem_w_en), 32'd0);
            check($sformatf("cks_s_ready%0d", pass), 32'(s_ready), 32'd1);
            tick(); s_valid = 1'b0;
            mid();
            check($sformatf("cks_prog_ready%0d", pass), 32'(prog_ready), (pass == 0) ? 32'd1 : 32'd0);
            check($sformatf("cks_error%0d", pass), 32'(error), (pass == 0) ? 32'd0 : 32'd1);
        end
        tick(); start = 1'b1; prog_len = 9'd1;
        tick(); start = 1'b0;
        mid(); check("cks_error_cleared", 32'(error), 32'd0);
        tick(); s_valid = 1'b1; s_data = 32'h5;
        tick(); s_data = 32'h5;
        tick(); s_valid = 1'b0;
        mid(); check("cks_len1_run", 32'(prog_ready), 32'd1);
`else
        check("error_tied_low", 32'(error), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
